// File: rtl/regfile_dump.sv
// Walks every register: dumps them over a valid/ready port or clears them through the write port.
// Latency: dump word 0 is presented two cycles after start is accepted; clear writes begin the next cycle.
// Backpressure: outReady low holds the presented word indefinitely; start is ignored while busy.
module regfile_dump #(
   parameter int DBITS = 32,
   parameter int ABITS = 4,
   parameter int WORDS = (1 << ABITS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             clrMode,
   output logic [ABITS-1:0] rdInd,
   input  logic [DBITS-1:0] rdData,
   output logic             wrtEn,
   output logic [ABITS-1:0] wrtInd,
   output logic [DBITS-1:0] dIn,
   output logic             outValid,
   input  logic             outReady,
   output logic [ABITS-1:0] outInd,
   output logic [DBITS-1:0] outData,
   output logic             outLast,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SEND  = 3'd2,
      CLEAR = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [ABITS-1:0] LAST_IDX = ABITS'(WORDS - 1);
   localparam logic [ABITS-1:0] ONE      = ABITS'(1);

   state_t           state;
   logic [ABITS-1:0] idx;

   // Sequencer: one index counter shared by the dump and clear walks; it parks at the last index
   // instead of wrapping, and the captured word is held untouched while SEND waits for outReady.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         idx     <= '0;
         outData <= '0;
         outInd  <= '0;
         outLast <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx   <= '0;
                  state <= clrMode ? CLEAR : FETCH;
               end
            end
            FETCH: begin
               outData <= rdData;
               outInd  <= idx;
               outLast <= (idx == LAST_IDX);
               state   <= SEND;
            end
            SEND: begin
               if (outReady) begin
                  if (idx == LAST_IDX) begin
                     state <= DONE;
                  end else begin
                     idx   <= idx + ONE;
                     state <= FETCH;
                  end
               end
            end
            CLEAR: begin
               if (idx == LAST_IDX) begin
                  state <= DONE;
               end else begin
                  idx <= idx + ONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status and strobes are pure decodes of the state flop, so reset drops them immediately.
   always_comb begin
      outValid = (state == SEND);
      wrtEn    = (state == CLEAR);
      busy     = (state != IDLE);
      done     = (state == DONE);
      rdInd    = idx;
      wrtInd   = idx;
      dIn      = '0;
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: behavioural register file, table of whole-walk scenarios, scoreboard of dump words.
// Cycle c of a scenario is the interval after the c-th rising edge counted from the edge that samples start.
// Hand-written sequences cover reset values and an asynchronous reset while a word is stalled in SEND.
module tb_regfile_dump;

   localparam int DBITS = 32;
   localparam int ABITS = 4;
   localparam int WORDS = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             clrMode;
   logic [ABITS-1:0] rdInd;
   logic [DBITS-1:0] rdData;
   logic             wrtEn;
   logic [ABITS-1:0] wrtInd;
   logic [DBITS-1:0] dIn;
   logic             outValid;
   logic             outReady;
   logic [ABITS-1:0] outInd;
   logic [DBITS-1:0] outData;
   logic             outLast;
   logic             busy;
   logic             done;

   regfile_dump #(.DBITS(DBITS), .ABITS(ABITS), .WORDS(WORDS)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .clrMode(clrMode),
      .rdInd(rdInd), .rdData(rdData), .wrtEn(wrtEn), .wrtInd(wrtInd), .dIn(dIn),
      .outValid(outValid), .outReady(outReady), .outInd(outInd), .outData(outData),
      .outLast(outLast), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Behavioural register file: combinational read, clocked write, bench-controlled preload.
   logic [DBITS-1:0] regs   [WORDS];
   logic [DBITS-1:0] golden [WORDS];
   logic             do_preload = 1'b0;

   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < WORDS; i++) regs[i] <= DBITS'(32'h100 + i);
      end else if (wrtEn) begin
         regs[wrtInd] <= dIn;
      end
   end

   assign rdData = regs[rdInd];

   typedef struct packed {
      logic [ABITS-1:0] ind;
      logic [DBITS-1:0] data;
      logic             last;
   } item_t;

   item_t sb[$];

   typedef struct {
      logic clr;
      logic preload;
      int   stall_word;
      int   stall_len;
      int   pulse_at;
      int   exp_done;
      int   exp_words;
      int   exp_writes;
      int   exp_first;
   } vec_t;

   vec_t tbl[5];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic preload();
      @(negedge clk);
      do_preload = 1'b1;
      @(negedge clk);
      do_preload = 1'b0;
      for (int i = 0; i < WORDS; i++) golden[i] = DBITS'(32'h100 + i);
   endtask

   task automatic run(input vec_t v);
      int c;
      int done_cnt;
      int done_at;
      int first_act;
      int writes;
      int words;
      int stall_left;
      int nonzero;
      if (v.preload) preload();
      sb.delete();
      if (!v.clr) begin
         for (int i = 0; i < WORDS; i++)
            sb.push_back('{ind: ABITS'(i), data: golden[i], last: (i == WORDS - 1)});
      end
      @(negedge clk);
      start      = 1'b1;
      clrMode    = v.clr;
      outReady   = 1'b1;
      done_cnt   = 0;
      done_at    = -1;
      first_act  = -1;
      writes     = 0;
      words      = 0;
      stall_left = v.stall_len;
      for (c = 1; c <= v.exp_done + 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         start   = (c == v.pulse_at);
         clrMode = (c == v.pulse_at) ? 1'b1 : v.clr;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if ((outValid || wrtEn) && first_act < 0) first_act = c;
         check("busy", busy, (done_at < 0 || c == done_at));
         if (wrtEn) begin
            check("wrtInd", wrtInd, writes);
            check("dIn", dIn, 0);
            writes++;
         end
         if (outValid) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               check("outInd", outInd, sb[0].ind);
               check("outData", outData, sb[0].data);
               check("outLast", outLast, sb[0].last);
               if (stall_left > 0 && int'(outInd) == v.stall_word) begin
                  outReady = 1'b0;
                  stall_left--;
               end else begin
                  outReady = 1'b1;
                  void'(sb.pop_front());
                  words++;
               end
            end
         end else begin
            outReady = 1'b1;
         end
      end
      check("done_pulses", done_cnt, 1);
      check("done_cycle", done_at, v.exp_done);
      check("words", words, v.exp_words);
      check("writes", writes, v.exp_writes);
      check("first_active_cycle", first_act, v.exp_first);
      check("sb_left", sb.size(), 0);
      check("idle_after", busy, 0);
      if (v.clr) begin
         nonzero = 0;
         for (int i = 0; i < WORDS; i++) begin
            if (regs[i] !== '0) nonzero++;
            golden[i] = '0;
         end
         check("regs_cleared", nonzero, 0);
      end
   endtask

   task automatic reset_mid_dump();
      int found;
      preload();
      found = 0;
      @(negedge clk);
      start    = 1'b1;
      clrMode  = 1'b0;
      outReady = 1'b1;
      for (int c = 1; c <= 40 && found == 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (outValid && outInd == 4'd7) begin
            outReady = 1'b0;
            found    = 1;
         end
      end
      check("reach_word7", found, 1);
      repeat (2) @(negedge clk);
      check("stalled_word7", outInd, 7);
      check("stalled_data7", outData, 32'h107);
      #2 reset_n = 1'b0;
      #1;
      check("rst_outValid", outValid, 0);
      check("rst_busy", busy, 0);
      check("rst_outInd", outInd, 0);
      check("rst_outData", outData, 0);
      check("rst_rdInd", rdInd, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_hold_wrtEn", wrtEn, 0);
         check("rst_hold_outValid", outValid, 0);
      end
      reset_n  = 1'b1;
      outReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_rst_busy", busy, 0);
         check("post_rst_outValid", outValid, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //             clr   pre   stall_w stall_n pulse done words writes first
      tbl[0] = '{1'b0, 1'b1, -1, 0, -1, 33, 16, 0, 2};
      tbl[1] = '{1'b0, 1'b1, 3, 5, -1, 38, 16, 0, 2};
      tbl[2] = '{1'b1, 1'b0, -1, 0, -1, 17, 0, 16, 1};
      tbl[3] = '{1'b0, 1'b0, -1, 0, -1, 33, 16, 0, 2};
      tbl[4] = '{1'b0, 1'b1, -1, 0, 10, 33, 16, 0, 2};

      reset_n  = 1'b0;
      start    = 1'b0;
      clrMode  = 1'b0;
      outReady = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outValid", outValid, 0);
      check("reset_wrtEn", wrtEn, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_wrtInd", wrtInd, 0);
      check("reset_rdInd", rdInd, 0);
      check("reset_dIn", dIn, 0);
      check("reset_outInd", outInd, 0);
      check("reset_outData", outData, 0);
      check("reset_outLast", outLast, 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_without_start", busy, 0);

      for (int t = 0; t < 5; t++) run(tbl[t]);

      reset_mid_dump();
      run(tbl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
